// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector.
// Compares the last PAT_WIDTH accepted bits against a loadable pattern,
// emits a registered one-cycle detect pulse and keeps a saturating count.
// Optional build macro SEQ_MASK_EN adds a per-bit don't-care mask (mask_in).
module seq_detector_param #(
  parameter int unsigned            PAT_WIDTH     = 4,
  parameter logic [PAT_WIDTH-1:0]   RESET_PATTERN = 4'b1101,
  parameter int unsigned            CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i,
  input  logic                 i_valid,
  input  logic                 overlap_en,
  input  logic                 load,
  input  logic [PAT_WIDTH-1:0] pattern_in,
`ifdef SEQ_MASK_EN
  input  logic [PAT_WIDTH-1:0] mask_in,
`endif
  input  logic                 clr_count,
  output logic                 o,
  output logic [CNT_WIDTH-1:0] match_count
);

  localparam int unsigned FW = $clog2(PAT_WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_WIDTH);

  logic [PAT_WIDTH-1:0] pattern;
  logic [PAT_WIDTH-1:0] hist;
  logic [FW-1:0]        fill;
`ifdef SEQ_MASK_EN
  logic [PAT_WIDTH-1:0] mask;
`endif

  logic [PAT_WIDTH-1:0] cand_c;
  logic [FW-1:0]        candfill_c;
  logic [PAT_WIDTH-1:0] care_c;
  logic                 accept_c;
  logic                 match_c;

  // Candidate history/fill for this cycle and the match decision
  always_comb begin
    cand_c     = {hist[PAT_WIDTH-2:0], i};
    candfill_c = (fill == FULL) ? FULL : fill + FW'(1);
`ifdef SEQ_MASK_EN
    care_c     = ~mask;
`else
    care_c     = '1;
`endif
    accept_c   = i_valid & ~load;
    match_c    = accept_c && (candfill_c == FULL) &&
                 (((cand_c ^ pattern) & care_c) == '0);
  end

  // Pattern, history, fill and detect pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pattern <= RESET_PATTERN;
      hist    <= '0;
      fill    <= '0;
      o       <= 1'b0;
`ifdef SEQ_MASK_EN
      mask    <= '0;
`endif
    end else if (load) begin
      pattern <= pattern_in;
      hist    <= '0;
      fill    <= '0;
      o       <= 1'b0;
`ifdef SEQ_MASK_EN
      mask    <= mask_in;
`endif
    end else if (i_valid) begin
      if (match_c) begin
        o <= 1'b1;
        if (overlap_en) begin
          hist <= cand_c;
          fill <= FULL;
        end else begin
          hist <= '0;
          fill <= '0;
        end
      end else begin
        hist <= cand_c;
        fill <= candfill_c;
        o    <= 1'b0;
      end
    end else begin
      o <= 1'b0;
    end
  end

  // Saturating match counter; a coincident clear wins
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= '0;
    end else if (match_c && !(&match_count)) begin
      match_count <= match_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed-vector bench for seq_detector_param.
// Two instances share stimulus: default counter width and a 2-bit counter.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       i, i_valid, overlap_en, load, clr_count;
  logic [3:0] pattern_in;
  logic [3:0] mask_in;
  logic       o, o2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .n_rst(n_rst), .i(i), .i_valid(i_valid),
    .overlap_en(overlap_en), .load(load), .pattern_in(pattern_in),
`ifdef SEQ_MASK_EN
    .mask_in(mask_in),
`endif
    .clr_count(clr_count), .o(o), .match_count(match_count)
  );

  seq_detector_param #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .i(i), .i_valid(i_valid),
    .overlap_en(overlap_en), .load(load), .pattern_in(pattern_in),
`ifdef SEQ_MASK_EN
    .mask_in(mask_in),
`endif
    .clr_count(clr_count), .o(o2), .match_count(match_count2)
  );

  // Count one comparison and report a mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, then sample just after the edge
  task automatic step(input logic v, input logic b);
    i_valid = v;
    i       = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Send n bits MSB first; exp holds the required o after each bit
  task automatic send(input string tag, input logic [31:0] bits, input int n,
                      input logic [31:0] exp);
    for (int k = n - 1; k >= 0; k--) begin
      step(1'b1, bits[k]);
      chk(tag, 32'(o), 32'(exp[k]));
    end
  endtask

  task automatic do_reset(input string tag);
    n_rst = 1'b0;
    #3;
    chk({tag, "_rst_o"}, 32'(o), 32'd0);
    chk({tag, "_rst_cnt"}, 32'(match_count), 32'd0);
    n_rst = 1'b1;
  endtask

  task automatic do_load(input string tag, input logic [3:0] pat,
                         input logic [3:0] msk, input logic b);
    load       = 1'b1;
    pattern_in = pat;
    mask_in    = msk;
    step(1'b1, b);
    chk(tag, 32'(o), 32'd0);
    load = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; i = 1'b0; i_valid = 1'b0; overlap_en = 1'b1;
    load = 1'b0; clr_count = 1'b0; pattern_in = '0; mask_in = '0;
    @(posedge clk);
    #1;

    // Reset defaults: 1101 detects once
    do_reset("init");
    send("rst_def", 32'b1101, 4, 32'b0001);
    chk("rst_def_cnt", 32'(match_count), 32'd1);
    step(1'b0, 1'b0);
    chk("rst_def_pulse_end", 32'(o), 32'd0);

    // Overlapping search
    do_reset("ov");
    overlap_en = 1'b1;
    send("ov", 32'b1101101, 7, 32'b0001001);
    chk("ov_cnt", 32'(match_count), 32'd2);
    chk("ov_cnt2", 32'(match_count2), 32'd2);

    // Non-overlapping search
    do_reset("nov");
    overlap_en = 1'b0;
    send("nov", 32'b1101101, 7, 32'b0001000);
    chk("nov_cnt", 32'(match_count), 32'd1);
    overlap_en = 1'b1;

    // Stall tolerance with i toggling while invalid
    do_reset("stall");
    send("stall_a", 32'b11, 2, 32'b00);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, k[0]);
      chk("stall_idle", 32'(o), 32'd0);
    end
    send("stall_b", 32'b01, 2, 32'b01);
    chk("stall_cnt", 32'(match_count), 32'd1);

    // Reload mid-stream; load-cycle bit 0 must be discarded
    do_reset("rl");
    send("rl_pre", 32'b10, 2, 32'b00);
    do_load("rl_load", 4'b0110, 4'b0000, 1'b0);
    send("rl_110", 32'b110, 3, 32'b000);
    send("rl_0110", 32'b0110, 4, 32'b0001);
    chk("rl_cnt", 32'(match_count), 32'd1);
    do_load("rl_load2", 4'b0110, 4'b0000, 1'b1);
    send("rl_old", 32'b1101, 4, 32'b0000);
    chk("rl_cnt_kept", 32'(match_count), 32'd1);

    // Reset mid-pattern restores the reset pattern
    send("mid_pre", 32'b01, 2, 32'b00);
    do_reset("mid");
    send("mid_post", 32'b1101, 4, 32'b0001);

    // Counter saturation: five overlapping matches
    do_reset("sat");
    send("sat", 32'b1101101101101101, 16, 32'b0001001001001001);
    chk("sat_cnt8", 32'(match_count), 32'd5);
    chk("sat_cnt2", 32'(match_count2), 32'd3);

    // Clear coincident with a match: clear wins, pulse still seen
    do_reset("clr");
    send("clr_pre", 32'b110110, 6, 32'b000100);
    chk("clr_pre_cnt", 32'(match_count), 32'd1);
    clr_count = 1'b1;
    step(1'b1, 1'b1);
    clr_count = 1'b0;
    chk("clr_o", 32'(o), 32'd1);
    chk("clr_cnt", 32'(match_count), 32'd0);
    chk("clr_cnt2", 32'(match_count2), 32'd0);

`ifdef SEQ_MASK_EN
    // Mask bit 1 is don't-care
    do_load("mk_load1", 4'b1101, 4'b0010, 1'b0);
    send("mk_1101", 32'b1101, 4, 32'b0001);
    do_load("mk_load2", 4'b1101, 4'b0010, 1'b0);
    send("mk_1111", 32'b1111, 4, 32'b0001);
    do_load("mk_load3", 4'b1101, 4'b0010, 1'b0);
    send("mk_0101", 32'b0101, 4, 32'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial pattern detector. It is the successor to the lab fixed-pattern Moore detector.
- Samples one serial bit per qualified clock and compares the last PAT_WIDTH bits against a loadable pattern.
- Raises a registered (Moore) one-cycle detect pulse and keeps a saturating match count.
- Sits on a serial input stream in front of framing/sync logic; supports overlapping and non-overlapping search.

Parameters:
- PAT_WIDTH, 4, pattern length in bits; legal range 2..32.
- RESET_PATTERN, 4'b1101, pattern register value after reset; width PAT_WIDTH; newest bit in LSB.
- CNT_WIDTH, 8, width of the match counter.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- i  input  1  serial data bit.
- i_valid  input  1  qualifies i; the bit is consumed only when high.
- overlap_en  input  1  1 = overlapping search, 0 = non-overlapping; sampled on the match cycle.
- load  input  1  one-cycle strobe to capture pattern_in.
- pattern_in  input  PAT_WIDTH  new pattern; newest bit in LSB.
- clr_count  input  1  synchronous clear of match_count.
- o  output  1  registered detect pulse.
- match_count  output  CNT_WIDTH  saturating number of matches.

Behaviour:
- Reset (n_rst low, asynchronous):
  - pattern register = RESET_PATTERN.
  - history = 0, fill = 0, o = 0, match_count = 0.
- State: history shift register hist[PAT_WIDTH-1:0] and fill counter fill in 0..PAT_WIDTH.
- Accepted bit (i_valid=1, load=0):
  - cand = {hist[PAT_WIDTH-2:0], i}.
  - candfill = min(fill+1, PAT_WIDTH).
  - hist <= cand.
- Match condition: accepted bit AND candfill == PAT_WIDTH AND cand == pattern.
- On a match:
  - o is high in the following cycle only; this is a Moore-style registered output with 1-cycle latency from the sampling edge.
  - overlap_en=1: fill <= PAT_WIDTH, history retained. Example: pattern 1101 on stream 1101101 gives two pulses.
  - overlap_en=0: fill <= 0 and hist <= 0; the next match needs PAT_WIDTH fresh bits.
  - match_count increments, saturating at all-ones (no wrap).
- No match on an accepted bit: fill <= candfill and o <= 0.
- i_valid=0: hist and fill hold; o <= 0. Stalls between bits of a pattern do not break the match.
- load=1 (top priority over i_valid; the bit in that cycle is discarded):
  - pattern <= pattern_in.
  - hist <= 0, fill <= 0, o <= 0.
  - match_count unaffected.
- clr_count=1: match_count <= 0. If a match occurs in the same cycle, the clear wins and the count is 0; o still pulses.
- Partial patterns never match: no detect until PAT_WIDTH valid bits have been accepted since reset, load, or a non-overlap match. This prevents false hits on reset-zero history.
- Reset mid-stream discards all history immediately.
- o is a pure function of registered state; there is no combinational path from i to o.

Optional Feature:
- Macro SEQ_MASK_EN.
- When defined:
  - Extra port mask_in, input, PAT_WIDTH wide, captured with pattern_in on load.
  - Mask register resets to 0.
  - Bits where mask=1 are don't-care in the compare: match requires (cand ^ pattern) & ~mask == 0.
  - The fill rule is unchanged.
- When undefined: no mask_in port, no mask register, exact compare on all bits.

Test Plan:
- Reset defaults:
  - Stimulus: after reset, i_valid=1 every cycle, stream 1,1,0,1, overlap_en=1.
  - Required: o=1 in exactly one cycle, the cycle after the 4th bit edge; match_count=1.
- Overlap vs non-overlap:
  - Stimulus: stream 1101101 with overlap_en=1.
  - Required: o pulses after bits 4 and 7; count=2.
  - Stimulus: same stream with overlap_en=0.
  - Required: one pulse; count=1.
- Stall tolerance:
  - Stimulus: stream 1,1,0,1 with i_valid low for 3 cycles between bits 2 and 3, and i toggling while invalid.
  - Required: exactly one pulse.
- Reload:
  - Stimulus: load pattern 4'b0110 mid-stream, then 0110.
  - Required: the bit in the load cycle is ignored and a single pulse follows.
  - Stimulus: stream 1101 after the reload.
  - Required: no pulse.
  - Stimulus: reset n_rst mid-pattern.
  - Required: o=0, count=0, pattern back to 1101.
- Counter:
  - Stimulus: CNT_WIDTH=2, 5 matches.
  - Required: count saturates at 3.
  - Stimulus: clr_count coincident with a match.
  - Required: count=0 and o still pulses.
- Mask (SEQ_MASK_EN):
  - Stimulus: pattern 1101 with mask 0010.
  - Required: streams 1101 and 1111 both detect; 0101 does not.
